// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the SD host register-bank arbiter.
package reg_bus_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_NUM_REQ    = 3;
    localparam int unsigned TO_CNT_WIDTH   = 8;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_CMD = 1;
    localparam int unsigned PORT_DAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
    } reg_bus_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the port after last_grant has highest priority.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c
);

    logic found;

    // Walk offsets 1..NUM_REQ from last_grant; first requester found wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (32'(last_grant) + k) % NUM_REQ)) begin
                    grant_c[i]  = 1'b1;
                    grant_idx_c = IDX_W'(i);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-bank req/ack port between three requesters,
// with an ack timeout and a release phase that waits out a stale ack.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = REG_NUM_REQ,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             p_req,
    input  logic [NUM_REQ-1:0]             p_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  p_wdata,
    output logic [NUM_REQ-1:0]             p_ack,
    output logic [NUM_REQ-1:0]             p_err,
    output logic [DATA_WIDTH-1:0]          p_rdata,
    output logic                           reg_req,
    output logic                           reg_rw,
    output logic [ADDR_WIDTH-1:0]          reg_addr,
    output logic [DATA_WIDTH-1:0]          reg_wdata,
    input  logic [DATA_WIDTH-1:0]          reg_rdata,
    input  logic                           reg_ack
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = TO_CNT_WIDTH;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    reg_bus_state_t state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
    logic [NUM_REQ-1:0]    p_ack_d, p_err_d;
    logic [DATA_WIDTH-1:0] p_rdata_d;
    logic                  reg_req_d, reg_rw_d;
    logic [ADDR_WIDTH-1:0] reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_d;

    logic [NUM_REQ-1:0]    pick_c;
    logic [IDX_W-1:0]      pick_idx_c;
    logic                  sel_rw_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (p_req),
        .last_grant  (last_grant_q),
        .grant_c     (pick_c),
        .grant_idx_c (pick_idx_c)
    );

    // One-hot mux of the winning port's fields.
    always_comb begin
        sel_rw_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c[i]) begin
                sel_rw_c    = p_rw[i];
                sel_addr_c  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_c = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            to_cnt_q     <= '0;
            p_ack        <= '0;
            p_err        <= '0;
            p_rdata      <= '0;
            reg_req      <= 1'b0;
            reg_rw       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            to_cnt_q     <= to_cnt_d;
            p_ack        <= p_ack_d;
            p_err        <= p_err_d;
            p_rdata      <= p_rdata_d;
            reg_req      <= reg_req_d;
            reg_rw       <= reg_rw_d;
            reg_addr     <= reg_addr_d;
            reg_wdata    <= reg_wdata_d;
        end
    end

    // Next-state and output logic; bank-side fields hold unless a new grant is latched.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        to_cnt_d     = to_cnt_q;
        p_ack_d      = '0;
        p_err_d      = '0;
        p_rdata_d    = p_rdata;
        reg_req_d    = reg_req;
        reg_rw_d     = reg_rw;
        reg_addr_d   = reg_addr;
        reg_wdata_d  = reg_wdata;

        case (state_q)
            ST_IDLE: begin
                if (|pick_c) begin
                    grant_d     = pick_idx_c;
                    reg_rw_d    = sel_rw_c;
                    reg_addr_d  = sel_addr_c;
                    reg_wdata_d = sel_wdata_c;
                    reg_req_d   = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (reg_ack) begin
                    reg_req_d        = 1'b0;
                    p_rdata_d        = reg_rw ? reg_rdata : '0;
                    p_ack_d[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = ST_RELEASE;
                end else if (to_cnt_q == TO_LAST) begin
                    reg_req_d        = 1'b0;
                    p_rdata_d        = '0;
                    p_ack_d[grant_q] = 1'b1;
                    p_err_d[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = ST_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // A lingering ack must not complete the next access.
                if (!reg_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: transaction-level round-robin model vs. DUT acks.
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    p_req, p_rw, p_ack, p_err;
    logic [NR*AW-1:0] p_addr;
    logic [NR*DW-1:0] p_wdata;
    logic [DW-1:0]    p_rdata, reg_wdata, reg_rdata;
    logic             reg_req, reg_rw, reg_ack;
    logic [AW-1:0]    reg_addr;

    reg_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
        .reg_req(reg_req), .reg_rw(reg_rw), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack)
    );

    typedef struct { bit rw; bit [4:0] addr; bit [31:0] wdata; } op_t;
    typedef struct { int port; bit err; bit [31:0] rdata; int cyc; } exp_t;

    op_t  pq [3][$];
    exp_t sb [$];
    bit [31:0] bank_mem [32];
    bit [31:0] model_mem [32];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int req_hi = 0;
    int model_last;
    int bank_lat = 0;
    int bank_stk = 0;
    bit bank_noack = 1'b0;
    int bcnt, bhold;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural register bank: ack registered after bank_lat sampled req cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ack <= 1'b0; reg_rdata <= '0; bcnt <= 0; bhold <= 0;
        end else if (reg_ack) begin
            if (bhold > 0) bhold <= bhold - 1;
            else reg_ack <= 1'b0;
            bcnt <= 0;
        end else if (reg_req && !bank_noack) begin
            if (bcnt == bank_lat) begin
                reg_ack <= 1'b1;
                bhold   <= bank_stk;
                bcnt    <= 0;
                if (reg_rw) reg_rdata <= bank_mem[reg_addr];
                else begin
                    bank_mem[reg_addr] = reg_wdata;
                    reg_rdata <= '0;
                end
            end else bcnt <= bcnt + 1;
        end else bcnt <= 0;
    end

    always @(negedge clk) if (reg_req) req_hi++;

    // Monitor: every ack pops one expected completion.
    always @(negedge clk) begin
        if (rst_n && p_ack != '0) begin
            exp_t e;
            chk("ack_onehot", $countones(p_ack), 1);
            if (sb.size() == 0) chk("unexpected_ack", longint'(p_ack), 0);
            else begin
                e = sb.pop_front();
                chk("ack_port", longint'(p_ack), longint'(1) << e.port);
                chk("ack_err", longint'(p_err), e.err ? (longint'(1) << e.port) : 0);
                chk("ack_rdata", longint'(p_rdata), longint'(e.rdata));
                chk("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic add(int port, bit rw, bit [4:0] addr, bit [31:0] wdata);
        op_t o;
        o.rw = rw; o.addr = addr; o.wdata = wdata;
        pq[port].push_back(o);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (pq[i].size() > 0) begin
                p_req[i]            = 1'b1;
                p_rw[i]             = pq[i][0].rw;
                p_addr[i*AW +: AW]  = pq[i][0].addr;
                p_wdata[i*DW +: DW] = pq[i][0].wdata;
            end else p_req[i] = 1'b0;
        end
    endtask

    // Transaction-level model: serve queued ops round-robin, one access per slot.
    task automatic predict(int t0);
        op_t q [3][$];
        int t, w;
        op_t o;
        exp_t e;
        t = t0;
        for (int i = 0; i < NR; i++) q[i] = pq[i];
        while (q[0].size() + q[1].size() + q[2].size() > 0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (model_last + k) % NR;
                if (w < 0 && q[c].size() > 0) w = c;
            end
            o = q[w].pop_front();
            e.port  = w;
            e.err   = bank_noack;
            e.rdata = (o.rw && !bank_noack) ? model_mem[o.addr] : 32'h0;
            if (!o.rw && !bank_noack) model_mem[o.addr] = o.wdata;
            e.cyc   = bank_noack ? t + 2 + TO : t + 3 + bank_lat;
            sb.push_back(e);
            model_last = w;
            t = bank_noack ? t + 3 + TO : t + 4 + bank_lat + bank_stk;
        end
    endtask

    task automatic start();
        int n;
        n = 0;
        predict(cyc);
        drive();
        while (pq[0].size() + pq[1].size() + pq[2].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NR; i++) if (p_ack[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            drive();
        end
        chk("drain_pending", pq[0].size() + pq[1].size() + pq[2].size(), 0);
        for (int i = 0; i < NR; i++) pq[i].delete();
        drive();
        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        p_req = '0; p_rw = '0; p_addr = '0; p_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            bank_mem[i]  = $urandom;
            model_mem[i] = bank_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_reg_req", reg_req, 0);
        chk("rst_reg_rw", reg_rw, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_p_ack", p_ack, 0);
        chk("rst_p_err", p_err, 0);
        chk("rst_p_rdata", p_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        model_last = NR - 1;

        // Contention from reset, port 0 re-requests immediately.
        add(PORT_CPU, 1'b1, 5'h01, 32'h0);
        add(PORT_CPU, 1'b1, 5'h02, 32'h0);
        add(PORT_CMD, 1'b0, 5'h07, 32'h1234_5678);
        add(PORT_DAT, 1'b1, 5'h07, 32'h0);
        start();

        // Single read with a known bank value; req held exactly two cycles.
        bank_mem[3] = 32'hA5A5_0011;
        model_mem[3] = 32'hA5A5_0011;
        req_hi = 0;
        add(PORT_CPU, 1'b1, 5'h03, 32'h0);
        start();
        chk("req_high_cycles", req_hi, 2);

        // Write reaches the bank; p_rdata returns 0.
        add(PORT_DAT, 1'b0, 5'h18, 32'hDEAD_BEEF);
        start();
        chk("bank_write_24", bank_mem[24], 32'hDEAD_BEEF);

        // Bank never acknowledges.
        bank_noack = 1'b1;
        add(PORT_CMD, 1'b1, 5'h04, 32'h0);
        start();
        bank_noack = 1'b0;

        // Ack stuck high for 5 extra cycles delays the queued second access.
        bank_stk = 5;
        add(PORT_CPU, 1'b1, 5'h03, 32'h0);
        add(PORT_CPU, 1'b0, 5'h05, 32'h0BAD_F00D);
        start();
        bank_stk = 0;

        // Randomized mixes of requesters, bank latency and stuck ack.
        repeat (30) begin
            int tot;
            tot = 0;
            bank_lat = $urandom_range(0, 3);
            bank_stk = $urandom_range(0, 2);
            for (int i = 0; i < NR; i++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) add(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
                tot += n;
            end
            if (tot == 0) add($urandom_range(0, 2), 1'b1, 5'($urandom_range(0, 31)), 32'h0);
            start();
        end
        bank_lat = 0;
        bank_stk = 0;

        // Mid-access reset: last served is port 0, yet port 0 must win after reset.
        add(PORT_CPU, 1'b1, 5'h09, 32'h0);
        start();
        bank_lat = 10;
        add(PORT_CMD, 1'b1, 5'h0A, 32'h0);
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_reg_req", reg_req, 0);
        chk("midrst_p_ack", p_ack, 0);
        for (int i = 0; i < NR; i++) pq[i].delete();
        sb.delete();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        bank_lat = 0;
        model_last = NR - 1;
        @(negedge clk);
        add(PORT_DAT, 1'b1, 5'h0B, 32'h0);
        add(PORT_CMD, 1'b1, 5'h0C, 32'h0);
        add(PORT_CPU, 1'b1, 5'h0D, 32'h0);
        start();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
